// File: rtl/alarm_sequencer.sv
// Alarm-clock alarm sequencer: DISARMED/ARMED/RINGING/SNOOZE control with pulsed
// buzzer, bounded snooze count, seconds countdown and a sticky missed-alarm flag.
module alarm_sequencer #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3,
  parameter int CNT_W       = 9,
  localparam int SNZ_W      = $clog2(MAX_SNOOZE + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_1hz,
  input  logic             match,
  input  logic             enable,
  input  logic             stop_btn,
  input  logic             snooze_btn,
  output logic [1:0]       state_o,
  output logic             buzzer,
  output logic [SNZ_W-1:0] snooze_cnt,
  output logic [CNT_W-1:0] secs_left,
  output logic             missed
);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RINGING  = 2'd2,
    ST_SNOOZE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RING_LD   = CNT_W'(RING_SECS);
  localparam logic [CNT_W-1:0] SNOOZE_LD = CNT_W'(SNOOZE_SECS);
  localparam logic [CNT_W-1:0] SECS_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] SECS_ZERO = CNT_W'(0);
  localparam logic [SNZ_W-1:0] SNZ_MAX   = SNZ_W'(MAX_SNOOZE);
  localparam logic [SNZ_W-1:0] SNZ_ZERO  = SNZ_W'(0);
  localparam logic [SNZ_W-1:0] SNZ_ONE   = SNZ_W'(1);

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] secs_r, secs_nxt_s;
  logic [SNZ_W-1:0] snz_r, snz_nxt_s;
  logic             missed_r, missed_nxt_s;
  logic             phase_r, phase_nxt_s;
  logic             buzzer_r;
  logic             match_q_r, stop_q_r, snooze_q_r;
  logic             match_rise_s, stop_rise_s, snooze_rise_s;
  logic             timeout_s;

  assign match_rise_s  = match & ~match_q_r;
  assign stop_rise_s   = stop_btn & ~stop_q_r;
  assign snooze_rise_s = snooze_btn & ~snooze_q_r;
  assign timeout_s     = tick_1hz & (secs_r == SECS_ONE);

  // State, datapath and edge-detect registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_DISARMED;
      secs_r     <= SECS_ZERO;
      snz_r      <= SNZ_ZERO;
      missed_r   <= 1'b0;
      phase_r    <= 1'b0;
      buzzer_r   <= 1'b0;
      match_q_r  <= 1'b0;
      stop_q_r   <= 1'b0;
      snooze_q_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      secs_r     <= secs_nxt_s;
      snz_r      <= snz_nxt_s;
      missed_r   <= missed_nxt_s;
      phase_r    <= phase_nxt_s;
      buzzer_r   <= (state_nxt_s == ST_RINGING) & phase_nxt_s;
      match_q_r  <= match;
      stop_q_r   <= stop_btn;
      snooze_q_r <= snooze_btn;
    end
  end

  // Next-state logic; enable low overrides everything
  always_comb begin
    state_nxt_s = state_r;
    if (!enable) begin
      state_nxt_s = ST_DISARMED;
    end else begin
      case (state_r)
        ST_DISARMED: state_nxt_s = ST_ARMED;
        ST_ARMED:    state_nxt_s = match_rise_s ? ST_RINGING : ST_ARMED;
        ST_RINGING: begin
          if (stop_rise_s)                             state_nxt_s = ST_ARMED;
          else if (snooze_rise_s && (snz_r < SNZ_MAX)) state_nxt_s = ST_SNOOZE;
          else if (timeout_s)                          state_nxt_s = ST_ARMED;
          else                                         state_nxt_s = ST_RINGING;
        end
        ST_SNOOZE: begin
          if (stop_rise_s)    state_nxt_s = ST_ARMED;
          else if (timeout_s) state_nxt_s = ST_RINGING;
          else                state_nxt_s = ST_SNOOZE;
        end
        default: state_nxt_s = ST_DISARMED;
      endcase
    end
  end

  // Next values of the registered outputs; loads take precedence over countdown
  always_comb begin
    secs_nxt_s   = secs_r;
    snz_nxt_s    = snz_r;
    phase_nxt_s  = phase_r;
    missed_nxt_s = missed_r;
    if (!enable) begin
      secs_nxt_s   = SECS_ZERO;
      snz_nxt_s    = SNZ_ZERO;
      phase_nxt_s  = 1'b0;
      missed_nxt_s = 1'b0;
    end else begin
      if (stop_rise_s) missed_nxt_s = 1'b0;
      else             missed_nxt_s = missed_r;
      case (state_r)
        ST_ARMED: begin
          if (match_rise_s) begin
            secs_nxt_s  = RING_LD;
            phase_nxt_s = 1'b1;
            snz_nxt_s   = SNZ_ZERO;
          end else begin
            secs_nxt_s  = secs_r;
          end
        end
        ST_RINGING: begin
          if (stop_rise_s) begin
            secs_nxt_s  = SECS_ZERO;
            snz_nxt_s   = SNZ_ZERO;
            phase_nxt_s = 1'b0;
          end else if (snooze_rise_s && (snz_r < SNZ_MAX)) begin
            secs_nxt_s = SNOOZE_LD;
            snz_nxt_s  = snz_r + SNZ_ONE;
          end else if (tick_1hz && (secs_r > SECS_ONE)) begin
            secs_nxt_s  = secs_r - SECS_ONE;
            phase_nxt_s = ~phase_r;
          end else if (timeout_s) begin
            secs_nxt_s   = SECS_ZERO;
            snz_nxt_s    = SNZ_ZERO;
            phase_nxt_s  = 1'b0;
            missed_nxt_s = 1'b1;
          end else begin
            secs_nxt_s = secs_r;
          end
        end
        ST_SNOOZE: begin
          if (stop_rise_s) begin
            secs_nxt_s = SECS_ZERO;
            snz_nxt_s  = SNZ_ZERO;
          end else if (tick_1hz && (secs_r > SECS_ONE)) begin
            secs_nxt_s = secs_r - SECS_ONE;
          end else if (timeout_s) begin
            secs_nxt_s  = RING_LD;
            phase_nxt_s = 1'b1;
          end else begin
            secs_nxt_s = secs_r;
          end
        end
        default: secs_nxt_s = secs_r;
      endcase
    end
  end

  assign state_o    = state_r;
  assign buzzer     = buzzer_r;
  assign snooze_cnt = snz_r;
  assign secs_left  = secs_r;
  assign missed     = missed_r;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed self-checking bench for alarm_sequencer (RING_SECS=60, SNOOZE_SECS=5).
module tb_alarm_sequencer;

  logic       clk;
  logic       rst_n;
  logic       tick_1hz;
  logic       match;
  logic       enable;
  logic       stop_btn;
  logic       snooze_btn;
  logic [1:0] state_o;
  logic       buzzer;
  logic [1:0] snooze_cnt;
  logic [8:0] secs_left;
  logic       missed;

  int n_checks;
  int n_fail;

  alarm_sequencer #(
    .RING_SECS  (60),
    .SNOOZE_SECS(5),
    .MAX_SNOOZE (3),
    .CNT_W      (9)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_1hz  (tick_1hz),
    .match     (match),
    .enable    (enable),
    .stop_btn  (stop_btn),
    .snooze_btn(snooze_btn),
    .state_o   (state_o),
    .buzzer    (buzzer),
    .snooze_cnt(snooze_cnt),
    .secs_left (secs_left),
    .missed    (missed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one active edge, then back to the sampling/driving point
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1'b1;
      cyc();
      tick_1hz = 1'b0;
      cyc();
    end
  endtask

  task automatic ring();
    match = 1'b1;
    cyc();
    match = 1'b0;
    cyc();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0; tick_1hz = 1'b0; match = 1'b0; enable = 1'b0;
    stop_btn = 1'b0; snooze_btn = 1'b0;
    cyc(); cyc();
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_buzzer", 32'(buzzer), 32'd0);
    check("rst_secs", 32'(secs_left), 32'd0);
    check("rst_snz", 32'(snooze_cnt), 32'd0);
    check("rst_missed", 32'(missed), 32'd0);

    rst_n = 1'b1; enable = 1'b1;
    cyc();
    check("arm_state", 32'(state_o), 32'd1);

    // T2 ring + stop
    match = 1'b1;
    cyc();
    check("t2_state", 32'(state_o), 32'd2);
    check("t2_secs", 32'(secs_left), 32'd60);
    check("t2_buzz", 32'(buzzer), 32'd1);
    match = 1'b0;
    cyc();
    ticks(3);
    check("t2_secs57", 32'(secs_left), 32'd57);
    check("t2_buzz57", 32'(buzzer), 32'd0);
    stop_btn = 1'b1;
    cyc();
    check("t2_stop_state", 32'(state_o), 32'd1);
    check("t2_stop_buzz", 32'(buzzer), 32'd0);
    check("t2_stop_secs", 32'(secs_left), 32'd0);
    stop_btn = 1'b0;
    cyc();

    // T5 tick coincident with match rise, then stop+snooze together
    match = 1'b1; tick_1hz = 1'b1;
    cyc();
    check("t5_load_secs", 32'(secs_left), 32'd60);
    check("t5_load_state", 32'(state_o), 32'd2);
    match = 1'b0; tick_1hz = 1'b0;
    cyc();
    stop_btn = 1'b1; snooze_btn = 1'b1;
    cyc();
    check("t5_both_state", 32'(state_o), 32'd1);
    check("t5_both_snz", 32'(snooze_cnt), 32'd0);
    stop_btn = 1'b0; snooze_btn = 1'b0;
    cyc();

    // T3 snooze limit
    ring();
    for (int i = 1; i <= 3; i++) begin
      snooze_btn = 1'b1;
      cyc();
      snooze_btn = 1'b0;
      check("t3_snz_state", 32'(state_o), 32'd3);
      check("t3_snz_cnt", 32'(snooze_cnt), 32'(i));
      check("t3_snz_secs", 32'(secs_left), 32'd5);
      check("t3_snz_buzz", 32'(buzzer), 32'd0);
      cyc();
      if (i == 1) begin
        snooze_btn = 1'b1;
        cyc();
        snooze_btn = 1'b0;
        check("t3_snz_ignored", 32'(snooze_cnt), 32'd1);
        cyc();
      end
      ticks(4);
      check("t3_secs1", 32'(secs_left), 32'd1);
      check("t3_still_snz", 32'(state_o), 32'd3);
      ticks(1);
      check("t3_rering", 32'(state_o), 32'd2);
      check("t3_rering_secs", 32'(secs_left), 32'd60);
      check("t3_rering_buzz", 32'(buzzer), 32'd1);
    end
    snooze_btn = 1'b1;
    cyc();
    snooze_btn = 1'b0;
    check("t3_limit_state", 32'(state_o), 32'd2);
    check("t3_limit_cnt", 32'(snooze_cnt), 32'd3);
    cyc();
    stop_btn = 1'b1;
    cyc();
    stop_btn = 1'b0;
    check("t3_stop_cnt", 32'(snooze_cnt), 32'd0);
    cyc();

    // T4 timeout, match rise while ringing ignored
    ring();
    ticks(1);
    match = 1'b1;
    cyc();
    match = 1'b0;
    check("t4_no_retrig", 32'(secs_left), 32'd59);
    cyc();
    ticks(58);
    check("t4_secs1", 32'(secs_left), 32'd1);
    check("t4_buzz_off", 32'(buzzer), 32'd0);
    ticks(1);
    check("t4_to_state", 32'(state_o), 32'd1);
    check("t4_missed", 32'(missed), 32'd1);
    check("t4_to_secs", 32'(secs_left), 32'd0);
    stop_btn = 1'b1;
    cyc();
    stop_btn = 1'b0;
    check("t4_missed_clr", 32'(missed), 32'd0);
    cyc();

    // T6 enable drop in SNOOZE, then re-enable with match held high
    ring();
    snooze_btn = 1'b1;
    cyc();
    snooze_btn = 1'b0;
    check("t6_snz_state", 32'(state_o), 32'd3);
    enable = 1'b0;
    cyc();
    check("t6_dis_state", 32'(state_o), 32'd0);
    check("t6_dis_cnt", 32'(snooze_cnt), 32'd0);
    check("t6_dis_secs", 32'(secs_left), 32'd0);
    match = 1'b1;
    cyc();
    enable = 1'b1;
    cyc();
    check("t6_rearm", 32'(state_o), 32'd1);
    cyc(); cyc();
    check("t6_no_ring", 32'(state_o), 32'd1);
    match = 1'b0;
    cyc();
    match = 1'b1;
    cyc();
    check("t6_new_rise", 32'(state_o), 32'd2);
    match = 1'b0;
    cyc();

    // T1 async reset mid-ring
    rst_n = 1'b0;
    #1;
    check("t1_state", 32'(state_o), 32'd0);
    check("t1_buzz", 32'(buzzer), 32'd0);
    check("t1_secs", 32'(secs_left), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("t1_rearm", 32'(state_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
